// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the FSM state encoding, the data word width and the address range check.
package mem_responder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Any address bit at or above the BRAM word-address width makes the request unreachable.
    function automatic logic addrOutOfRange(input logic [WORD_W-1:0] addr, input int addrW);
        return (addr >> addrW) != '0;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that flags the last cycle of a BRAM read wait.
// Loaded with RD_LAT on a read acceptance; o_done is high in the final wait cycle.
module mem_lat_counter #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    localparam int CNT_W = 2;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(RD_LAT);
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder between the multicycle control FSM and a single-port BRAM.
// Serves one fetch, load or store at a time and latches fetched instructions.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_fetch,
    input  logic [WORD_W-1:0] i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [WORD_W-1:0] o_rsp_rdata,
    output logic [WORD_W-1:0] o_instr_out,
    output logic              o_instr_valid,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic [WORD_W-1:0] i_mem_rdata
);

    state_t              r_state;
    logic                r_reqReady;
    logic                r_rspValid;
    logic                r_err;
    logic                r_badReq;
    logic                r_isFetch;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [WORD_W-1:0]   r_memWdata;
    logic [WORD_W-1:0]   r_instrOut;
    logic                r_instrValid;

    logic                w_accept;
    logic                w_badReq;
    logic                w_loadCnt;
    logic                w_latDone;

    assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
    assign w_badReq  = addrOutOfRange(i_req_addr, ADDR_W) || (i_req_we && i_req_fetch);
    assign w_loadCnt = w_accept && !w_badReq && !i_req_we;

    mem_lat_counter #(
        .RD_LAT(RD_LAT)
    ) u_latCounter (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_loadCnt),
        .o_done(w_latDone)
    );

    // Rejected requests skip the BRAM entirely and answer from RESP with err set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_reqReady   <= 1'b1;
            r_rspValid   <= 1'b0;
            r_err        <= 1'b0;
            r_badReq     <= 1'b0;
            r_isFetch    <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_instrOut   <= '0;
            r_instrValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_reqReady <= 1'b0;
                        r_badReq   <= w_badReq;
                        r_isFetch  <= i_req_fetch && !w_badReq;
                        if (w_badReq) begin
                            r_state    <= ST_RESP;
                            r_rspValid <= 1'b1;
                            r_err      <= 1'b1;
                        end else if (i_req_we) begin
                            r_state    <= ST_WRITE;
                            r_memWe    <= 1'b1;
                            r_memAddr  <= i_req_addr[ADDR_W-1:0];
                            r_memWdata <= i_req_wdata;
                            r_rspValid <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_WAIT;
                            r_memAddr <= i_req_addr[ADDR_W-1:0];
                            if (i_req_fetch) begin
                                r_instrValid <= 1'b0;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    r_memWe    <= 1'b0;
                    r_rspValid <= 1'b0;
                    r_reqReady <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (w_latDone) begin
                        r_state    <= ST_RESP;
                        r_rspValid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rspValid <= 1'b0;
                    r_err      <= 1'b0;
                    r_reqReady <= 1'b1;
                    r_state    <= ST_IDLE;
                    if (r_isFetch) begin
                        r_instrOut   <= i_mem_rdata;
                        r_instrValid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // BRAM data is only present during RESP, so read data is steered straight from the BRAM output register.
    assign o_rsp_rdata   = ((r_state == ST_RESP) && !r_badReq) ? i_mem_rdata : '0;
    assign o_req_ready   = r_reqReady;
    assign o_rsp_valid   = r_rspValid;
    assign o_err         = r_err;
    assign o_mem_we      = r_memWe;
    assign o_mem_addr    = r_memAddr;
    assign o_mem_wdata   = r_memWdata;
    assign o_instr_out   = r_instrOut;
    assign o_instr_valid = r_instrValid;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (RD_LAT=1 and RD_LAT=2) against BRAM models
// and a transaction-level reference of memory contents, latency and the latched instruction.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    logic              reqValid [2];
    logic              reqWe    [2];
    logic              reqFetch [2];
    logic [15:0]       reqAddr  [2];
    logic [15:0]       reqWdata [2];
    logic              reqReady [2];
    logic              rspValid [2];
    logic [15:0]       rspRdata [2];
    logic [15:0]       instrOut [2];
    logic              instrValid [2];
    logic              err      [2];
    logic [ADDR_W-1:0] memAddr  [2];
    logic              memWe    [2];
    logic [15:0]       memWdata [2];
    logic [15:0]       memRdata [2];

    // BRAM models: contents default to a fixed per-address pattern until written.
    logic [15:0] bramData    [2][DEPTH];
    bit          bramWritten [2][DEPTH];
    logic [15:0] rd1 [2];
    logic [15:0] rd2 [2];

    // Reference state: memory image and the instruction register as the control path should see it.
    logic [15:0] mData    [2][DEPTH];
    bit          mWritten [2][DEPTH];
    logic [15:0] expInstr [2];
    logic        expIV    [2];

    int checks;
    int failures;

    always #5 clk = ~clk;

    function automatic logic [15:0] seedWord(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] modelRead(input int d, input logic [15:0] a);
        int idx;
        idx = int'(a[ADDR_W-1:0]);
        return mWritten[d][idx] ? mData[d][idx] : seedWord(a & 16'h03FF);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gDut
        mem_responder #(
            .ADDR_W(ADDR_W),
            .RD_LAT(g + 1)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .i_req_valid  (reqValid[g]),
            .o_req_ready  (reqReady[g]),
            .i_req_we     (reqWe[g]),
            .i_req_fetch  (reqFetch[g]),
            .i_req_addr   (reqAddr[g]),
            .i_req_wdata  (reqWdata[g]),
            .o_rsp_valid  (rspValid[g]),
            .o_rsp_rdata  (rspRdata[g]),
            .o_instr_out  (instrOut[g]),
            .o_instr_valid(instrValid[g]),
            .o_err        (err[g]),
            .o_mem_addr   (memAddr[g]),
            .o_mem_we     (memWe[g]),
            .o_mem_wdata  (memWdata[g]),
            .i_mem_rdata  (memRdata[g])
        );
    end

    // Synchronous BRAM with one output register, plus a second stage for the two-cycle instance.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rd1[g] <= bramWritten[g][memAddr[g]] ? bramData[g][memAddr[g]] : seedWord(16'(memAddr[g]));
            rd2[g] <= rd1[g];
            if (memWe[g]) begin
                bramData[g][memAddr[g]]    <= memWdata[g];
                bramWritten[g][memAddr[g]] <= 1'b1;
            end
        end
    end

    assign memRdata[0] = rd1[0];
    assign memRdata[1] = rd2[1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction on instance d; starts and ends one cycle after the previous response.
    task automatic applyStimulus(input int d, input bit we, input bit fetch,
                                 input logic [15:0] addr, input logic [15:0] wdata, input bit busyJunk);
        bit          bad;
        bit          seen;
        int          lat;
        logic [15:0] expData;
        bad     = ((addr >> ADDR_W) != 0) || (we && fetch);
        lat     = (bad || we) ? 1 : 2 + d;
        expData = bad ? 16'h0000 : modelRead(d, addr);
        seen    = 1'b0;

        checkOutput("ready_idle", 32'(reqReady[d]), 32'd1);
        checkOutput("rsp_idle", 32'(rspValid[d]), 32'd0);
        checkOutput("instr_out", 32'(instrOut[d]), 32'(expInstr[d]));
        checkOutput("instr_valid", 32'(instrValid[d]), 32'(expIV[d]));

        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqFetch[d] = fetch;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;

        for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (busyJunk) begin
                reqValid[d] = 1'b1;
                reqWe[d]    = 1'($urandom);
                reqFetch[d] = 1'($urandom);
                reqAddr[d]  = 16'($urandom_range(31, 0));
                reqWdata[d] = 16'($urandom);
            end else begin
                reqValid[d] = 1'b0;
            end
            if (rspValid[d] === 1'b1) begin
                seen = 1'b1;
                checkOutput("latency", 32'(cyc), 32'(lat));
                checkOutput("rsp_err", 32'(err[d]), 32'(bad));
                checkOutput("rsp_mem_we", 32'(memWe[d]), 32'(we && !bad));
                if (!we || bad) begin
                    checkOutput("rsp_rdata", 32'(rspRdata[d]), 32'(expData));
                end else begin
                    checkOutput("wr_addr", 32'(memAddr[d]), 32'(addr & 16'h03FF));
                    checkOutput("wr_data", 32'(memWdata[d]), 32'(wdata));
                end
            end else begin
                checkOutput("busy_ready", 32'(reqReady[d]), 32'd0);
                checkOutput("busy_mem_we", 32'(memWe[d]), 32'd0);
                checkOutput("busy_err", 32'(err[d]), 32'd0);
                if (cyc == 1) begin
                    checkOutput("rd_addr", 32'(memAddr[d]), 32'(addr & 16'h03FF));
                    if (fetch) begin
                        checkOutput("fetch_clears_iv", 32'(instrValid[d]), 32'd0);
                    end
                end
            end
        end
        if (!seen) begin
            checkOutput("rsp_timeout", 32'(rspValid[d]), 32'd1);
        end

        if (!bad) begin
            if (we) begin
                mData[d][int'(addr[ADDR_W-1:0])]    = wdata;
                mWritten[d][int'(addr[ADDR_W-1:0])] = 1'b1;
            end else if (fetch) begin
                expInstr[d] = expData;
                expIV[d]    = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b1;
            reqWe[d]    = 1'b0;
            reqFetch[d] = 1'b1;
            reqAddr[d]  = 16'h0001;
            reqWdata[d] = 16'h0000;
            expInstr[d] = 16'h0000;
            expIV[d]    = 1'b0;
        end

        // Held in reset with a request pending: everything must stay at its reset value.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ready", 32'(reqReady[d]), 32'd1);
            checkOutput("rst_rsp_valid", 32'(rspValid[d]), 32'd0);
            checkOutput("rst_mem_we", 32'(memWe[d]), 32'd0);
            checkOutput("rst_instr_valid", 32'(instrValid[d]), 32'd0);
            checkOutput("rst_instr_out", 32'(instrOut[d]), 32'd0);
            checkOutput("rst_mem_addr", 32'(memAddr[d]), 32'd0);
            checkOutput("rst_rdata", 32'(rspRdata[d]), 32'd0);
            checkOutput("rst_err", 32'(err[d]), 32'd0);
            reqValid[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checkOutput("post_rst_rsp", 32'(rspValid[d]), 32'd0);
                checkOutput("post_rst_we", 32'(memWe[d]), 32'd0);
            end
        end

        $display("[TB] directed store/load, RD_LAT=1");
        applyStimulus(0, 1'b1, 1'b0, 16'h0005, 16'hBEEF, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0);

        $display("[TB] directed fetch/load, RD_LAT=2");
        applyStimulus(1, 1'b1, 1'b0, 16'h0010, 16'h1234, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0011, 16'hAAAA, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);

        $display("[TB] out-of-range and illegal requests");
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b1, 1'b0, 16'h0400, 16'h5555, 1'b0);
            applyStimulus(d, 1'b1, 1'b1, 16'h0010, 16'h6666, 1'b0);
            applyStimulus(d, 1'b0, 1'b1, 16'h8003, 16'h0000, 1'b0);
        end

        $display("[TB] busy handling and back-to-back");
        applyStimulus(1, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1);
        applyStimulus(1, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 16'h0006, 16'hC0DE, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            int          dSel;
            int          op;
            logic [15:0] a;
            dSel = int'($urandom_range(1, 0));
            op   = int'($urandom_range(7, 0));
            if ($urandom_range(7, 0) == 0) begin
                a = 16'h0400 | 16'($urandom_range(16'hFBFF, 0));
            end else begin
                a = 16'($urandom_range(31, 0));
            end
            applyStimulus(dSel, (op <= 2) || (op == 7), (op >= 5), a, 16'($urandom),
                          1'($urandom_range(1, 0)));
        end

        $display("[TB] reset in the middle of a store and a fetch");
        reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqFetch[0] = 1'b0; reqAddr[0] = 16'h0003; reqWdata[0] = 16'h7777;
        reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqFetch[1] = 1'b1; reqAddr[1] = 16'h0010; reqWdata[1] = 16'h0000;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        reqValid[1] = 1'b0;
        checkOutput("midrst_we_before", 32'(memWe[0]), 32'd1);
        checkOutput("midrst_busy", 32'(reqReady[1]), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_we_drop", 32'(memWe[0]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            checkOutput("midrst_ready", 32'(reqReady[d]), 32'd1);
            checkOutput("midrst_iv", 32'(instrValid[d]), 32'd0);
            expInstr[d] = 16'h0000;
            expIV[d]    = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checkOutput("midrst_no_rsp", 32'(rspValid[d]), 32'd0);
            end
        end
        applyStimulus(0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0);

        for (int d = 0; d < 2; d++) begin
            checkOutput("final_instr_out", 32'(instrOut[d]), 32'(expInstr[d]));
            checkOutput("final_instr_valid", 32'(instrValid[d]), 32'(expIV[d]));
            checkOutput("final_ready", 32'(reqReady[d]), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU control FSM.
- Accepts one fetch, load or store request at a time from the control path and drives a synchronous single-port block RAM.
- Returns read data with a valid pulse, and holds the fetched instruction stable for the decode/execute states.
- Sits between the control FSM/datapath and the BRAM.

Parameters:
- ADDR_W, 10, BRAM word-address width; depth = 2^ADDR_W words of 16 bits.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = read
- req_fetch  in  1  read is an instruction fetch
- req_addr  in  16  word address from the datapath
- req_wdata  in  16  store data
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  16  load/fetch data; valid only while rsp_valid=1
- instr_out  out  16  latched instruction
- instr_valid  out  1  instr_out holds a completed fetch
- err  out  1  one-cycle pulse: out-of-range address or illegal request
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  16  BRAM write data
- mem_rdata  in  16  BRAM read data, RD_LAT cycles after the address

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; req_ready=1; rsp_valid, mem_we, err and instr_valid = 0; rsp_rdata, instr_out and mem_addr = 0. Reset mid-operation aborts the transaction with no response. mem_we drops immediately.
- States: IDLE, WRITE, RD_WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready. req_addr, req_we, req_fetch and req_wdata are registered at acceptance. Inputs are ignored in all other states.
- Range check: req_addr[15:ADDR_W] must be 0, otherwise the request is out-of-range.
- Illegal request: req_we=1 with req_fetch=1.
- Out-of-range or illegal request:
  - No BRAM write.
  - Go to RESP next cycle.
  - rsp_valid=1 and err=1 in the same cycle; rsp_rdata=0.
  - instr_out/instr_valid unchanged.
- Store:
  - IDLE -> WRITE.
  - In WRITE: mem_we=1 for exactly one cycle; mem_addr and mem_wdata come from the registered request; rsp_valid=1 in that same cycle.
  - WRITE -> IDLE.
  - Latency: rsp_valid at acceptance edge +1 cycle.
- Read:
  - IDLE -> RD_WAIT. mem_addr is driven from the registered address.
  - An internal counter counts RD_LAT cycles, then moves to RESP.
  - In RESP: rsp_valid=1 and rsp_rdata=mem_rdata (registered).
  - Latency: rsp_valid at acceptance +1+RD_LAT cycles.
- Fetch, additionally:
  - instr_valid clears in the cycle after a fetch is accepted.
  - In RESP, instr_out <= mem_rdata and instr_valid <= 1 on the next edge.
  - instr_out holds until the next successful fetch; loads and stores never alter it.
- RESP -> IDLE unconditionally.
- Back-to-back: a new request is accepted at the earliest in the cycle after rsp_valid. There is no overlap or pipelining.
- mem_we=1 only in WRITE. mem_addr holds its last value in IDLE.
- Word addresses only; no byte enables. Address wrap is not performed; out-of-range raises err.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_WRITE, ST_RD_WAIT, ST_RESP;
  - data-width constant WORD_W=16.
- One natural sub-module, mem_lat_counter: loadable down-counter that asserts done after RD_LAT cycles.
- The BRAM itself is outside this block.

Test Plan:
- Reset: hold rst=0 with req_valid=1 -> req_ready=1, rsp_valid=0, mem_we=0, instr_valid=0. Release reset; no spurious response.
- Store then load, RD_LAT=1: store addr 0x0005 data 0xBEEF -> mem_we=1 with mem_addr=5 at accept+1, rsp_valid same cycle. Load addr 0x0005 -> rsp_valid at accept+2 with rsp_rdata=0xBEEF; instr_out unchanged.
- Fetch then load, RD_LAT=2: fetch addr 0x0010 (BRAM holds 0x1234) -> rsp_valid at accept+3, instr_out=0x1234, instr_valid=1. A later load of 0x0011 (0xAAAA) leaves instr_out=0x1234.
- Out-of-range store, ADDR_W=10: store addr 0x0400 -> no mem_we, rsp_valid=1 and err=1 at accept+1, rsp_rdata=0. Illegal request req_we=1, req_fetch=1 -> same response.
- Busy handling: assert req_valid continuously with changing addresses during RD_WAIT -> req_ready=0 and nothing captured. Next accept occurs in the cycle after rsp_valid.
- Reset mid-read: drop rst during RD_WAIT -> no rsp_valid, state IDLE, instr_valid=0. The next fetch completes normally.
